// File: rtl/sipo_frame_ctrl.sv
// Framed serial receiver: start bit (1), WIDTH data bits LSB-first, stop bit (0),
// with the assembled word handed off over a valid/ready handshake.
module sipo_frame_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  output logic [WIDTH-1:0] pout,
  output logic             pvalid,
  input  logic             pready,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    STOP  = 2'd2
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] r_pout;
  logic             r_pvalid;
  logic             r_busy;
  logic             r_frame_err;
  logic             r_overrun;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_sr        <= '0;
      r_pout      <= '0;
      r_pvalid    <= 1'b0;
      r_busy      <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
      // A consume may be overridden below by a same-edge load in STOP.
      if (r_pvalid && pready)
        r_pvalid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (sin) begin
            r_state <= SHIFT;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        SHIFT: begin
          r_sr  <= {sin, r_sr[WIDTH-1:1]};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(WIDTH - 1))
            r_state <= STOP;
        end
        STOP: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          if (sin) begin
            r_frame_err <= 1'b1;
          end else if (!r_pvalid || pready) begin
            r_pout   <= r_sr;
            r_pvalid <= 1'b1;
          end else begin
            r_overrun <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign pout      = r_pout;
  assign pvalid    = r_pvalid;
  assign busy      = r_busy;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;

endmodule
